// File: rtl/ariane_pkg.sv
// ariane_pkg: frontend/decode hand-off types and the realign FSM state encoding.
package ariane_pkg;
   localparam bit RVC = 1'b1;

   typedef struct packed {
      logic [riscv::XLEN-1:0] cause;
      logic [riscv::XLEN-1:0] tval;
      logic                   valid;
   } exception_t;

   typedef struct packed {
      logic [2:0]             cf;
      logic [riscv::VLEN-1:0] predict_address;
   } branchpredict_sbe_t;

   typedef struct packed {
      logic [riscv::VLEN-1:0] address;
      logic [31:0]            instruction;
      branchpredict_sbe_t     branch_predict;
      exception_t             ex;
   } fetch_entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_HALT} realign_state_t;
endpackage

// File: rtl/fetch_realign_queue_pkg.sv
// fetch_realign_queue_pkg: helpers that build decode-ready fetch entries.
package fetch_realign_queue_pkg;
   import ariane_pkg::*;

   // RVC encodings are everything except the 2'b11 quadrant.
   function automatic logic is_compressed(logic [1:0] low_bits);
      return low_bits != 2'b11;
   endfunction

   function automatic fetch_entry_t make_entry(logic [31:0] instr, logic [riscv::VLEN-1:0] addr);
      fetch_entry_t e;
      e = '0;
      e.address     = addr;
      e.instruction = instr;
      return e;
   endfunction

   function automatic fetch_entry_t make_ex_entry(logic [riscv::VLEN-1:0] addr,
                                                  logic [riscv::VLEN-1:0] tval);
      fetch_entry_t e;
      e = '0;
      e.address  = addr;
      e.ex.valid = 1'b1;
      e.ex.cause = riscv::INSTR_PAGE_FAULT;
      e.ex.tval  = riscv::XLEN'(tval);
      return e;
   endfunction
endpackage

// File: rtl/riscv.sv
// riscv: architectural constants shared by the fetch path.
package riscv;
   localparam int unsigned VLEN = 32;
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_PAGE_FAULT = XLEN'(12);
endpackage

// File: rtl/fetch_realign_queue_if.sv
// fetch_realign_queue_if: fetch-word input channel and fetch-entry output channel.
// master = frontend/decode environment, slave = the realign queue.
interface fetch_realign_queue_if;
   import ariane_pkg::*;
   logic                   fetch_valid_i;
   logic                   fetch_ready_o;
   logic [riscv::VLEN-1:0] fetch_addr_i;
   logic [31:0]            fetch_data_i;
   logic                   fetch_ex_i;
   fetch_entry_t           fetch_entry_o;
   logic                   fetch_entry_valid_o;
   logic                   fetch_entry_ready_i;

   modport master (output fetch_valid_i, fetch_addr_i, fetch_data_i, fetch_ex_i,
                   fetch_entry_ready_i,
                   input  fetch_ready_o, fetch_entry_o, fetch_entry_valid_o);
   modport slave  (input  fetch_valid_i, fetch_addr_i, fetch_data_i, fetch_ex_i,
                   fetch_entry_ready_i,
                   output fetch_ready_o, fetch_entry_o, fetch_entry_valid_o);
endinterface

// File: rtl/fetch_entry_fifo.sv
// fetch_entry_fifo: 2-push/1-pop entry FIFO with flush and free-slot count.
// Pointers carry a wrap bit above the index so full and empty are distinguishable.
module fetch_entry_fifo
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic [1:0]                push_i,
   input  fetch_entry_t              data0_i,
   input  fetch_entry_t              data1_i,
   input  logic                      pop_i,
   output fetch_entry_t              head_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    free_o
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0]  wr_q, wr_d, rd_q, rd_d, wr_next;
   logic         full;
   fetch_entry_t mem_q [DEPTH];
   fetch_entry_t mem_d [DEPTH];

   assign empty_o = (wr_q == rd_q);
   assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign free_o  = full ? '0 : (PW+1)'(DEPTH) - (wr_q - rd_q);
   assign head_o  = mem_q[rd_q[PW-1:0]];
   assign wr_next = wr_q + (PW+1)'(1);

   // Next pointers and storage: write up to two entries, retire one; flush wins.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_i != 2'd0) mem_d[wr_q[PW-1:0]]    = data0_i;
         if (push_i == 2'd2) mem_d[wr_next[PW-1:0]] = data1_i;
         wr_d = wr_q + (PW+1)'(push_i);
         if (pop_i && !empty_o) rd_d = rd_q + (PW+1)'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i)
                                  (PW+1)'(push_i) <= free_o);
endmodule

// File: rtl/fetch_realign_queue.sv
// fetch_realign_queue: splits 32-bit fetch words into RVC / 32-bit instructions,
// joins instructions straddling two words, and queues them for decode.
// Optional: FETCH_REALIGN_BYPASS_EN lets the first entry skip an empty FIFO.
module fetch_realign_queue
   import ariane_pkg::*;
   import fetch_realign_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter bit          RVC   = ariane_pkg::RVC
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   fetch_realign_queue_if.slave  fetch
);
   localparam int unsigned PW = $clog2(DEPTH);

   realign_state_t         state_q, state_d;
   logic [15:0]            hold_q, hold_d;
   logic [riscv::VLEN-1:0] hold_addr_q, hold_addr_d;
   logic [15:0]            lo, hi;
   logic [riscv::VLEN-1:0] addr, hi_addr;
   logic                   xfer, bypass;
   logic                   first_v, hi_v;
   fetch_entry_t           first_e, hi_e, e0, e1;
   logic [1:0]             n_push;
   fetch_entry_t           fifo_d0, fifo_d1, fifo_head;
   logic [1:0]             fifo_push;
   logic                   fifo_empty;
   logic [PW:0]            fifo_free;

   assign addr    = fetch.fetch_addr_i;
   assign lo      = fetch.fetch_data_i[15:0];
   assign hi      = fetch.fetch_data_i[31:16];
   assign hi_addr = {addr[riscv::VLEN-1:2], 2'b10};

   // Two free slots are always reserved so any transfer can land in full.
   assign fetch.fetch_ready_o = !rst_i && !flush_i && (state_q != ST_HALT) &&
                                (fifo_free >= (PW+1)'(2));
   assign xfer = fetch.fetch_valid_i && fetch.fetch_ready_o;

   // Realign FSM: next state, hold register and the 0..2 entries of this transfer.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_addr_d = hold_addr_q;
      first_v     = 1'b0;
      first_e     = '0;
      hi_v        = 1'b0;
      hi_e        = '0;
      e0          = '0;
      e1          = '0;
      n_push      = 2'd0;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else if (xfer) begin
         if (fetch.fetch_ex_i) begin
            e0      = make_ex_entry((state_q == ST_HOLD) ? hold_addr_q : addr, addr);
            n_push  = 2'd1;
            state_d = ST_HALT;
         end else if (!RVC || (state_q == ST_IDLE && !addr[1] && !is_compressed(lo[1:0]))) begin
            e0      = make_entry(fetch.fetch_data_i, addr);
            n_push  = 2'd1;
            state_d = ST_IDLE;
         end else begin
            if (state_q == ST_HOLD) begin
               first_v = 1'b1;
               first_e = make_entry({lo, hold_q}, hold_addr_q);
            end else if (!addr[1]) begin
               first_v = 1'b1;
               first_e = make_entry({16'h0, lo}, addr);
            end
            if (is_compressed(hi[1:0])) begin
               hi_v    = 1'b1;
               hi_e    = make_entry({16'h0, hi}, hi_addr);
               state_d = ST_IDLE;
            end else begin
               hold_d      = hi;
               hold_addr_d = hi_addr;
               state_d     = ST_HOLD;
            end
            if (first_v) begin
               e0     = first_e;
               e1     = hi_e;
               n_push = hi_v ? 2'd2 : 2'd1;
            end else begin
               e0     = hi_e;
               n_push = {1'b0, hi_v};
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Held upper half of a straddling instruction; only meaningful in ST_HOLD.
   always_ff @(posedge clk_i) begin
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
   end

`ifdef FETCH_REALIGN_BYPASS_EN
   assign bypass = fifo_empty && fetch.fetch_entry_ready_i && (n_push != 2'd0);
`else
   assign bypass = 1'b0;
`endif

   // FIFO write port: a bypassed first entry is not stored.
   always_comb begin
      fifo_d0   = e0;
      fifo_d1   = e1;
      fifo_push = n_push;
      if (bypass) begin
         fifo_d0   = e1;
         fifo_d1   = '0;
         fifo_push = n_push - 2'd1;
      end
   end

   fetch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (fifo_push),
      .data0_i (fifo_d0),
      .data1_i (fifo_d1),
      .pop_i   (fetch.fetch_entry_ready_i),
      .head_o  (fifo_head),
      .empty_o (fifo_empty),
      .free_o  (fifo_free)
   );

   assign fetch.fetch_entry_o       = bypass ? e0 : fifo_head;
   assign fetch.fetch_entry_valid_o = bypass || !fifo_empty;
endmodule

// File: tb/tb_fetch_realign_queue.sv
// tb_fetch_realign_queue: directed + randomized bench against a halfword-stream model.
module tb_fetch_realign_queue;
   import ariane_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   fetch_realign_queue_if ifc ();

   fetch_realign_queue #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .fetch   (ifc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] h;
      logic [31:0] a;
   } half_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        exv;
      logic [31:0] tval;
   } exp_t;

   half_t pend[$];
   exp_t  expq[$];
   bit    halted;
   int    total;
   int    bad;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit model_ready();
      return !flush && !halted && ((DEPTH - expq.size()) >= 2);
   endfunction

   task automatic emit(input logic [31:0] instr, input logic [31:0] addr);
      exp_t e;
      e.instr = instr; e.addr = addr; e.exv = 1'b0; e.tval = '0;
      expq.push_back(e);
   endtask

   // Model: a word contributes its halfwords to a stream; the stream is consumed
   // as whole instructions in address order.
   task automatic model_transfer(input logic [31:0] a, input logic [31:0] d, input bit ex);
      half_t hw;
      exp_t  e;
      if (ex) begin
         e.addr  = (pend.size() != 0) ? pend[0].a : a;
         e.instr = '0; e.exv = 1'b1; e.tval = a;
         expq.push_back(e);
         pend.delete();
         halted = 1'b1;
      end else begin
         if (!a[1]) begin
            hw.h = d[15:0]; hw.a = a & 32'hFFFF_FFFC;
            pend.push_back(hw);
         end
         hw.h = d[31:16]; hw.a = (a & 32'hFFFF_FFFC) | 32'h2;
         pend.push_back(hw);
         while (pend.size() != 0) begin
            if (pend[0].h[1:0] != 2'b11) begin
               emit({16'h0, pend[0].h}, pend[0].a);
               void'(pend.pop_front());
            end else if (pend.size() >= 2) begin
               emit({pend[1].h, pend[0].h}, pend[0].a);
               void'(pend.pop_front());
               void'(pend.pop_front());
            end else begin
               break;
            end
         end
      end
   endtask

   // One cycle: drive, compare DUT outputs to the model, advance the model.
   task automatic step(input bit fv, input logic [31:0] a, input logic [31:0] d,
                       input bit ex, input bit fl, input bit er, output bit took);
      @(negedge clk);
      ifc.fetch_valid_i       = fv;
      ifc.fetch_addr_i        = a;
      ifc.fetch_data_i        = d;
      ifc.fetch_ex_i          = ex;
      ifc.fetch_entry_ready_i = er;
      flush                   = fl;
      #1;
      check("fetch_ready", 64'(ifc.fetch_ready_o), 64'(model_ready()));
      check("entry_valid", 64'(ifc.fetch_entry_valid_o), 64'(expq.size() != 0));
      if (expq.size() != 0 && ifc.fetch_entry_valid_o) begin
         check("entry_addr",  64'(ifc.fetch_entry_o.address), 64'(expq[0].addr));
         check("entry_instr", 64'(ifc.fetch_entry_o.instruction), 64'(expq[0].instr));
         check("entry_exv",   64'(ifc.fetch_entry_o.ex.valid), 64'(expq[0].exv));
         check("entry_bp",    64'(ifc.fetch_entry_o.branch_predict), 64'(0));
         if (expq[0].exv) begin
            check("entry_tval",  64'(ifc.fetch_entry_o.ex.tval), 64'(expq[0].tval));
            check("entry_cause", 64'(ifc.fetch_entry_o.ex.cause), 64'(riscv::INSTR_PAGE_FAULT));
         end
      end
      took = fv && model_ready();
      if (fl) begin
         expq.delete();
         pend.delete();
         halted = 1'b0;
      end else begin
         if (er && expq.size() != 0) void'(expq.pop_front());
         if (took) model_transfer(a, d, ex);
      end
   endtask

   task automatic idle(input int n);
      bit t;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, t);
   endtask

   task automatic exp_is(input string name, input int idx, input logic [31:0] instr,
                         input logic [31:0] addr);
      if (idx >= expq.size()) begin
         check({name, "_present"}, 64'(expq.size()), 64'(idx + 1));
      end else begin
         check({name, "_instr"}, 64'(expq[idx].instr), 64'(instr));
         check({name, "_addr"},  64'(expq[idx].addr),  64'(addr));
      end
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
      else                           h[1:0] = 2'($urandom_range(2, 0));
      return h;
   endfunction

   initial begin
      bit          t;
      logic [31:0] pc;
      bit          fv, ex, fl, er;
      logic [31:0] d;
      total = 0; bad = 0; halted = 1'b0;
      rst = 1'b1; flush = 1'b0;
      ifc.fetch_valid_i = 1'b0; ifc.fetch_addr_i = '0; ifc.fetch_data_i = '0;
      ifc.fetch_ex_i = 1'b0; ifc.fetch_entry_ready_i = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      ifc.fetch_valid_i = 1'b1;
      #1;
      check("reset_ready", 64'(ifc.fetch_ready_o), 64'(0));
      check("reset_valid", 64'(ifc.fetch_entry_valid_o), 64'(0));
      @(negedge clk);
      ifc.fetch_valid_i = 1'b0;
      rst = 1'b0;

      // Two RVC instructions in one word.
      step(1'b1, 32'h8000_0000, 32'h0001_4501, 1'b0, 1'b0, 1'b0, t);
      exp_is("two_rvc0", 0, 32'h0000_4501, 32'h8000_0000);
      exp_is("two_rvc1", 1, 32'h0000_0001, 32'h8000_0002);
      idle(4);

      // One full 32-bit instruction.
      step(1'b1, 32'h8000_0000, 32'h00A0_0513, 1'b0, 1'b0, 1'b0, t);
      exp_is("word", 0, 32'h00A0_0513, 32'h8000_0000);
      check("word_count", 64'(expq.size()), 64'(1));
      idle(3);

      // Straddling instruction.
      step(1'b1, 32'h8000_0000, 32'h0513_4501, 1'b0, 1'b0, 1'b0, t);
      step(1'b1, 32'h8000_0004, 32'h0001_00A0, 1'b0, 1'b0, 1'b0, t);
      exp_is("strad0", 0, 32'h0000_4501, 32'h8000_0000);
      exp_is("strad1", 1, 32'h00A0_0513, 32'h8000_0002);
      exp_is("strad2", 2, 32'h0000_0001, 32'h8000_0006);
      idle(5);

      // Jump target on the upper half.
      step(1'b1, 32'h8000_0002, 32'h4501_0513, 1'b0, 1'b0, 1'b0, t);
      exp_is("jump", 0, 32'h0000_4501, 32'h8000_0002);
      check("jump_count", 64'(expq.size()), 64'(1));
      idle(3);

      // Flush while holding a half with three entries queued.
      step(1'b1, 32'h8000_0000, 32'h0001_4501, 1'b0, 1'b0, 1'b0, t);
      step(1'b1, 32'h8000_0004, 32'h0513_4501, 1'b0, 1'b0, 1'b0, t);
      check("preflush_count", 64'(expq.size()), 64'(3));
      check("preflush_hold", 64'(pend.size()), 64'(1));
      step(1'b1, 32'h8000_0008, 32'h0001_00A0, 1'b0, 1'b1, 1'b1, t);
      step(1'b1, 32'h8000_0010, 32'h0001_4501, 1'b0, 1'b0, 1'b0, t);
      exp_is("postflush0", 0, 32'h0000_4501, 32'h8000_0010);
      exp_is("postflush1", 1, 32'h0000_0001, 32'h8000_0012);
      idle(4);

      // Fault on the second half of a straddling instruction.
      step(1'b1, 32'h8000_0000, 32'h0513_4501, 1'b0, 1'b0, 1'b1, t);
      step(1'b1, 32'h8000_0004, 32'h1234_5678, 1'b1, 1'b0, 1'b0, t);
      check("fault_count", 64'(expq.size()), 64'(2));
      if (expq.size() == 2) begin
         check("fault_addr", 64'(expq[1].addr), 64'h8000_0002);
         check("fault_tval", 64'(expq[1].tval), 64'h8000_0004);
         check("fault_exv",  64'(expq[1].exv), 64'(1));
      end
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h8000_0008, 32'h0001_4501, 1'b0, 1'b0, 1'b1, t);
      check("halt_model_ready", 64'(halted), 64'(1));
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, t);

      // Backpressure: decode stalled, queue fills, then drains in order.
      step(1'b1, 32'h8000_0100, 32'h4501_4501, 1'b0, 1'b0, 1'b0, t);
      step(1'b1, 32'h8000_0104, 32'h0001_4505, 1'b0, 1'b0, 1'b0, t);
      step(1'b1, 32'h8000_0108, 32'h0001_4509, 1'b0, 1'b0, 1'b0, t);
      check("bp_count", 64'(expq.size()), 64'(4));
      exp_is("bp3", 3, 32'h0000_0001, 32'h8000_0106);
      idle(6);

      // Randomized traffic.
      pc = 32'h8000_0200;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         fl = halted ? ($urandom_range(99, 0) < 15) : ($urandom_range(99, 0) < 2);
         fv = ($urandom_range(99, 0) < 70);
         ex = fv && ($urandom_range(99, 0) < 2);
         er = ((cyc % 64) < 20) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
         d  = {rand_half(), rand_half()};
         step(fv, pc, d, ex, fl, er, t);
         if (fl) begin
            pc = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFE;
         end else if (t && !ex) begin
            pc = (pc & 32'hFFFF_FFFC) + 32'd4;
            if (pend.size() == 0 && $urandom_range(99, 0) < 5)
               pc = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFE;
         end
      end
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, t);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
